// File: rtl/mux_2_1.sv
// Registered 3-input WIDTH-bit selector with one cycle of latency.
// Optional illegal-select flag (sel == 3) enabled by defining MUX_2_1_SEL_ERR_EN.
module mux_2_1 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  input  logic [WIDTH-1:0] in_3,
  input  logic [1:0]       sel,
`ifdef MUX_2_1_SEL_ERR_EN
  output logic             sel_err,
`endif
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_data_next;
  logic             w_sel_legal;
  logic             w_load;

  assign w_sel_legal = (sel != 2'd3);
  // Code 3 selects nothing, so the register simply keeps its contents.
  assign w_load      = en & w_sel_legal;

  always_comb begin
    w_data_next = r_data;
    case (sel)
      2'd0:    w_data_next = in_1;
      2'd1:    w_data_next = in_2;
      2'd2:    w_data_next = in_3;
      default: w_data_next = r_data;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
    end else if (w_load) begin
      r_data <= w_data_next;
    end
  end

  assign data_out = r_data;

`ifdef MUX_2_1_SEL_ERR_EN
  logic r_sel_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_err <= 1'b0;
    end else if (en) begin
      r_sel_err <= ~w_sel_legal;
    end
  end

  assign sel_err = r_sel_err;
`endif

endmodule

// File: tb/tb_mux_2_1.sv
// Directed-vector bench for mux_2_1: a per-cycle model compare plus literal checks.
// Define MUX_2_1_SEL_ERR_EN for both files to cover the sel_err flag.
module tb_mux_2_1;
  localparam int WIDTH = 32;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic [WIDTH-1:0] in_1, in_2, in_3;
  logic [1:0]       sel;
  logic [WIDTH-1:0] data_out;
  logic             err_out;

  int checks   = 0;
  int failures = 0;
  bit chk_on   = 0;

  mux_2_1 #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .in_1     (in_1),
    .in_2     (in_2),
    .in_3     (in_3),
    .sel      (sel),
`ifdef MUX_2_1_SEL_ERR_EN
    .sel_err  (err_out),
`endif
    .data_out (data_out)
  );

`ifndef MUX_2_1_SEL_ERR_EN
  assign err_out = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: output is the most recently chosen legal source since reset.
  logic [WIDTH-1:0] m_data;
  logic             m_err;
  logic [WIDTH-1:0] src [3];

  always_comb begin
    src[0] = in_1;
    src[1] = in_2;
    src[2] = in_3;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data <= '0;
      m_err  <= 1'b0;
    end else if (en) begin
      if (int'(sel) < 3) m_data <= src[int'(sel)];
`ifdef MUX_2_1_SEL_ERR_EN
      m_err <= (int'(sel) == 3);
`endif
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      checks++;
      if (data_out !== m_data || err_out !== m_err) begin
        failures++;
        $display("FAIL model_cmp t=%0t data_out=%h err=%b required data_out=%h err=%b",
                 $time, data_out, err_out, m_data, m_err);
      end
    end
  end

  task automatic chk(input string name, input logic [WIDTH-1:0] exp_d, input logic exp_e);
    checks++;
`ifndef MUX_2_1_SEL_ERR_EN
    exp_e = 1'b0;
`endif
    if (data_out !== exp_d || err_out !== exp_e) begin
      failures++;
      $display("FAIL %s data_out=%h sel_err=%b required data_out=%h sel_err=%b",
               name, data_out, err_out, exp_d, exp_e);
    end else begin
      $display("ok   %s data_out=%h sel_err=%b", name, data_out, err_out);
    end
  endtask

  // Inputs change one time unit after a falling edge, away from the capture edge.
  task automatic apply(input logic e, input logic [1:0] s,
                       input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [WIDTH-1:0] c);
    @(negedge clk);
    #1;
    en = e; sel = s; in_1 = a; in_2 = b; in_3 = c;
  endtask

  task automatic edge_then(input string name, input logic [WIDTH-1:0] exp_d, input logic exp_e);
    @(posedge clk);
    #1;
    chk(name, exp_d, exp_e);
  endtask

  typedef struct {
    logic [1:0]       s;
    logic [WIDTH-1:0] a, b, c, exp_d;
    logic             exp_e;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{2'd0, 32'hDEADBEEF, 32'h1, 32'h2, 32'hDEADBEEF, 1'b0};
    vecs[1] = '{2'd1, 32'h0, 32'h80000000, 32'h7, 32'h80000000, 1'b0};
    vecs[2] = '{2'd3, 32'h5, 32'h6, 32'h7, 32'h80000000, 1'b1};
    vecs[3] = '{2'd2, 32'h5, 32'h6, 32'h00000001, 32'h00000001, 1'b0};
    vecs[4] = '{2'd3, 32'hA, 32'hB, 32'hC, 32'h00000001, 1'b1};
    vecs[5] = '{2'd1, 32'hA, 32'h12345678, 32'hC, 32'h12345678, 1'b0};

    rst_n = 1'b1; en = 1'b0; sel = 2'd0; in_1 = '0; in_2 = '0; in_3 = '0;
    #1 rst_n = 1'b0;
    #1 chk("reset_async", '0, 1'b0);
    chk_on = 1;

    @(negedge clk);
    #1;
    rst_n = 1'b1;
    apply(1'b1, 2'd0, 32'd5, 32'd0, 32'd0);
    edge_then("reset_release_load", 32'd5, 1'b0);

    apply(1'b1, 2'd0, 32'd84, 32'd132, 32'd28);
    edge_then("sel0", 32'd84, 1'b0);

    apply(1'b1, 2'd1, 32'd158, 32'd12, 32'd147);
    chk("sel1_before_edge", 32'd84, 1'b0);
    edge_then("sel1", 32'd12, 1'b0);

    apply(1'b1, 2'd2, 32'd39, 32'd471, 32'd36);
    edge_then("sel2", 32'd36, 1'b0);

    apply(1'b1, 2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    edge_then("sel2_all_ones", 32'hFFFFFFFF, 1'b0);

    apply(1'b1, 2'd2, 32'd39, 32'd471, 32'd36);
    edge_then("sel2_again", 32'd36, 1'b0);

    apply(1'b1, 2'd3, 32'd1, 32'd471, 32'd36);
    edge_then("sel3_hold", 32'd36, 1'b1);

    apply(1'b1, 2'd0, 32'd1, 32'd471, 32'd36);
    edge_then("sel0_after_illegal", 32'd1, 1'b0);

    apply(1'b0, 2'd3, 32'd7, 32'd8, 32'd9);
    edge_then("en0_sel3_err_holds", 32'd1, 1'b0);

    apply(1'b0, 2'd1, 32'd7, 32'd99, 32'd9);
    for (int i = 0; i < 3; i++) edge_then("en0_hold", 32'd1, 1'b0);

    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("midstream_reset", '0, 1'b0);
    en = 1'b1;
    rst_n = 1'b1;
    edge_then("reset_release_capture", 32'd99, 1'b0);

    foreach (vecs[i]) begin
      apply(1'b1, vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].c);
      edge_then($sformatf("vec%0d", i), vecs[i].exp_d, vecs[i].exp_e);
    end

    @(negedge clk);
    chk_on = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
